b08_src: RTL and testbench

- Stimulus/capture end of the b08 protocol: the counterpart that drives the b08 comparator core.
- Buffers up to DEPTH input bytes loaded over a valid/ready port.
- For each byte: presents it on I, pulses a START window, waits for the core to settle, then samples the 4-bit O result.
- Hands each result out over a valid/ready port. Sits between the test/host interface and a b08 instance.

---
 rtl/b08_src_if.sv | 26 ++
 rtl/b08_src.sv | 144 ++++++++++++++
 tb/tb_b08_src.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/b08_src_if.sv
// Handshake and core-facing signal bundle for b08_src.
// master is the b08_src side; slave is the host/core environment side.
interface b08_src_if;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       go;
  logic       start;
  logic [7:0] i;
  logic [3:0] o;
  logic       res_valid;
  logic [3:0] res_data;
  logic       res_ready;
  logic       busy;
  logic       done;

  modport master (
    input  ld_valid, ld_data, go, o, res_ready,
    output ld_ready, start, i, res_valid, res_data, busy, done
  );

  modport slave (
    output ld_valid, ld_data, go, o, res_ready,
    input  ld_ready, start, i, res_valid, res_data, busy, done
  );
endinterface

// File: rtl/b08_src.sv
// Stimulus/capture end of the b08 protocol: buffers bytes, drives each through a
// START window, samples O and hands results out. Optional replay: B08_SRC_LOOP_EN.
module b08_src #(
  parameter int DEPTH = 8,
  parameter int HOLD  = 11,
  parameter int GAP   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  b08_src_if.master  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(((HOLD > GAP) ? HOLD : GAP) + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CAPTURE} state_t;

  state_t         state;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  rd;
  logic [TW-1:0]  cnt;
  logic           start_q;
  logic [7:0]     i_q;
  logic           res_valid_q;
  logic [3:0]     res_data_q;
  logic           done_q;

  logic           ld_ready_c;
  logic           ld_fire;
  logic [CW-1:0]  count_ld;
  logic [CW-1:0]  rd_next;
  logic           last;

  // Loads are only accepted in IDLE; ready is forced low while reset is held.
  assign ld_ready_c = rst_n && (state == IDLE) && (count < CW'(DEPTH));
  assign ld_fire    = ld_ready_c && bus.ld_valid;
  assign count_ld   = count + {{(CW-1){1'b0}}, ld_fire};
  assign rd_next    = rd + {{(CW-1){1'b0}}, 1'b1};
  assign last       = (rd_next == count);

  assign bus.ld_ready  = ld_ready_c;
  assign bus.start     = start_q;
  assign bus.i         = i_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

  always_ff @(posedge clk) begin
    if (ld_fire)
      mem[wr] <= bus.ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr          <= '0;
      count       <= '0;
      rd          <= '0;
      cnt         <= '0;
      start_q     <= 1'b0;
      i_q         <= 8'h00;
      res_valid_q <= 1'b0;
      res_data_q  <= 4'h0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_fire)
            wr <= wr + AW'(1);
          count <= count_ld;
          // An empty buffer means slot 0 is being written this very cycle.
          if (bus.go && (count_ld != '0)) begin
            state   <= DRIVE;
            rd      <= '0;
            cnt     <= '0;
            start_q <= 1'b1;
            i_q     <= (count == '0) ? bus.ld_data : mem[0];
          end
        end

        DRIVE: begin
          if (cnt == TW'(HOLD - 1)) begin
            state   <= SETTLE;
            cnt     <= '0;
            start_q <= 1'b0;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end

        SETTLE: begin
          if (cnt == TW'(GAP - 1)) begin
            state       <= CAPTURE;
            cnt         <= '0;
            res_valid_q <= 1'b1;
            res_data_q  <= bus.o;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end

        CAPTURE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            if (last) begin
              done_q <= 1'b1;
`ifdef B08_SRC_LOOP_EN
              if (bus.go) begin
                rd      <= '0;
                state   <= DRIVE;
                start_q <= 1'b1;
                i_q     <= mem[0];
              end else begin
                state <= IDLE;
                count <= '0;
                wr    <= '0;
                rd    <= '0;
              end
`else
              state <= IDLE;
              count <= '0;
              wr    <= '0;
              rd    <= '0;
`endif
            end else begin
              rd      <= rd_next;
              state   <= DRIVE;
              start_q <= 1'b1;
              i_q     <= mem[rd_next[AW-1:0]];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_b08_src.sv
// Self-checking bench for b08_src: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_b08_src;
  localparam int DEPTH = 8;
  localparam int HOLD  = 11;
  localparam int GAP   = 2;
`ifdef B08_SRC_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  b08_src_if bus();

  b08_src #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the b08 core: result depends on I, and is garbage while START is high.
  function automatic logic [3:0] core_f(input logic [7:0] x);
    return x[7:4] ^ x[3:0] ^ 4'h6;
  endfunction

  assign bus.o = bus.start ? ~core_f(bus.i) : core_f(bus.i);

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered bytes in a queue, per-byte elapsed cycle count m_t.
  logic [7:0] mq[$];
  bit         m_run;
  int         m_idx;
  int         m_t;
  logic [3:0] m_res;
  logic [7:0] m_last;
  bit         m_done;
  bit         chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_run  = 1'b0;
      m_idx  = 0;
      m_t    = 0;
      m_res  = 4'h0;
      m_last = 8'h00;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_run) begin
        if (bus.ld_valid && mq.size() < DEPTH)
          mq.push_back(bus.ld_data);
        if (bus.go && mq.size() > 0) begin
          m_run = 1'b1;
          m_idx = 0;
          m_t   = 0;
        end
      end else if (m_t < HOLD + GAP) begin
        m_t++;
        if (m_t == HOLD + GAP)
          m_res = core_f(mq[m_idx]);
      end else if (bus.res_ready) begin
        m_idx++;
        m_t = 0;
        if (m_idx == mq.size()) begin
          m_done = 1'b1;
          if (LOOP && bus.go) begin
            m_idx = 0;
          end else begin
            m_last = mq[mq.size()-1];
            mq.delete();
            m_run = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("start",     32'(bus.start),     32'(m_run && m_t < HOLD));
      check_output("i",         32'(bus.i),         32'(m_run ? mq[m_idx] : m_last));
      check_output("busy",      32'(bus.busy),      32'(m_run));
      check_output("ld_ready",  32'(bus.ld_ready),  32'(rst_n && !m_run && mq.size() < DEPTH));
      check_output("res_valid", 32'(bus.res_valid), 32'(m_run && m_t == HOLD + GAP));
      check_output("res_data",  32'(bus.res_data),  32'(m_res));
      check_output("done",      32'(bus.done),      32'(m_done));
    end
  end

  // Event monitor feeding the directed scenarios.
  int         n_res;
  int         n_done;
  int         n_start_cycles;
  logic [7:0] starts[$];
  logic       prev_start = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.res_valid && bus.res_ready) n_res++;
      if (bus.done) n_done++;
      if (bus.start) n_start_cycles++;
      if (bus.start && !prev_start) starts.push_back(bus.i);
      prev_start = bus.start;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_res = 0;
    n_done = 0;
    n_start_cycles = 0;
    starts.delete();
  endtask

  task automatic load_byte(input logic [7:0] b);
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic pulse_go();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      if (!bus.busy) break;
      tick();
    end
    check_output({name, "_ends"}, 32'(bus.busy), 32'd0);
    repeat (2) tick();
  endtask

  task automatic apply_stimulus(input int n);
    for (int k = 0; k < n; k++) begin
      bus.ld_valid  = 1'($urandom_range(0, 1));
      bus.ld_data   = 8'($urandom);
      bus.go        = ($urandom_range(0, 15) == 0);
      bus.res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.ld_valid  = 1'b0;
    bus.go        = 1'b0;
    bus.res_ready = 1'b1;
    wait_idle(2000, "random");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         sc, bad, first_valid, st;
    logic [3:0] first_data, hold;
    bit         stable;

    bus.ld_valid  = 1'b0;
    bus.ld_data   = 8'h00;
    bus.go        = 1'b0;
    bus.res_ready = 1'b0;
    clear_mon();
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_output("reset_ld_ready", 32'(bus.ld_ready), 32'd1);
    check_output("reset_busy",     32'(bus.busy),     32'd0);

    // GO with an empty buffer is ignored.
    clear_mon();
    pulse_go();
    repeat (20) tick();
    check_output("go_empty_start", 32'(n_start_cycles), 32'd0);
    check_output("go_empty_busy",  32'(bus.busy),       32'd0);

    // Single byte timing.
    clear_mon();
    bus.res_ready = 1'b1;
    load_byte(8'hA5);
    pulse_go();
    sc = 0; bad = 0; first_valid = 0; first_data = 4'h0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (bus.start) begin
        sc++;
        if (bus.i !== 8'hA5) bad++;
      end
      if (bus.res_valid && first_valid == 0) begin
        first_valid = cyc;
        first_data  = bus.res_data;
      end
      if (!bus.busy) break;
      tick();
    end
    repeat (2) tick();
    check_output("single_start_cycles", 32'(sc),          32'd11);
    check_output("single_i_bad",        32'(bad),         32'd0);
    check_output("single_valid_cycle",  32'(first_valid), 32'd14);
    check_output("single_res_data",     32'(first_data),  32'h9);
    check_output("single_done_pulses",  32'(n_done),      32'd1);
    check_output("single_busy_after",   32'(bus.busy),    32'd0);

    // Fill to capacity; a ninth byte is refused.
    clear_mon();
    for (int k = 0; k < 8; k++) load_byte(8'(8'h10 + k));
    check_output("fill_ld_ready", 32'(bus.ld_ready), 32'd0);
    load_byte(8'h99);
    pulse_go();
    wait_idle(1000, "fill");
    check_output("fill_results", 32'(n_res),         32'd8);
    check_output("fill_dones",   32'(n_done),        32'd1);
    check_output("fill_nstarts", 32'(starts.size()), 32'd8);
    if (starts.size() == 8) begin
      check_output("fill_first_byte", 32'(starts[0]), 32'h10);
      check_output("fill_last_byte",  32'(starts[7]), 32'h17);
    end

    // Back-pressure on the first of two results.
    clear_mon();
    bus.res_ready = 1'b0;
    load_byte(8'h3C);
    load_byte(8'hC3);
    pulse_go();
    for (int k = 0; k < 100; k++) begin
      if (bus.res_valid) break;
      tick();
    end
    check_output("bp_result_seen", 32'(bus.res_valid), 32'd1);
    hold = bus.res_data;
    stable = 1'b1;
    st = 0;
    repeat (20) begin
      tick();
      if (bus.res_data !== hold || !bus.res_valid) stable = 1'b0;
      if (bus.start) st++;
    end
    check_output("bp_data_value",  32'(hold),   32'h9);
    check_output("bp_data_stable", 32'(stable), 32'd1);
    check_output("bp_no_start",    32'(st),     32'd0);
    bus.res_ready = 1'b1;
    wait_idle(500, "bp");
    check_output("bp_results", 32'(n_res), 32'd2);
    if (starts.size() == 2)
      check_output("bp_second_byte", 32'(starts[1]), 32'hC3);
    else
      check_output("bp_nstarts", 32'(starts.size()), 32'd2);

    // GO and a load in the same cycle.
    clear_mon();
    load_byte(8'h5A);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h6B;
    bus.go       = 1'b1;
    tick();
    bus.ld_valid = 1'b0;
    bus.go       = 1'b0;
    wait_idle(500, "simul");
    check_output("simul_results", 32'(n_res), 32'd2);
    if (starts.size() == 2) begin
      check_output("simul_byte0", 32'(starts[0]), 32'h5A);
      check_output("simul_byte1", 32'(starts[1]), 32'h6B);
    end else begin
      check_output("simul_nstarts", 32'(starts.size()), 32'd2);
    end

    // Reset asserted mid-DRIVE.
    clear_mon();
    load_byte(8'h11);
    load_byte(8'h22);
    pulse_go();
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_start",     32'(bus.start),     32'd0);
    check_output("rst_i",         32'(bus.i),         32'h00);
    check_output("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_output("rst_busy",      32'(bus.busy),      32'd0);
    check_output("rst_ld_ready",  32'(bus.ld_ready),  32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_output("rst_rel_ld_ready", 32'(bus.ld_ready), 32'd1);
    clear_mon();
    pulse_go();
    repeat (20) tick();
    check_output("rst_buffer_empty", 32'(n_start_cycles), 32'd0);

    if (LOOP) begin
      clear_mon();
      load_byte(8'h21);
      load_byte(8'h42);
      load_byte(8'h84);
      bus.go = 1'b1;
      tick();
      for (int k = 0; k < 2000; k++) begin
        if (n_done >= 2) break;
        tick();
      end
      bus.go = 1'b0;
      wait_idle(1000, "loop");
      check_output("loop_dones",   32'(n_done), 32'd3);
      check_output("loop_results", 32'(n_res),  32'd9);
      if (starts.size() == 9) begin
        check_output("loop_replay0", 32'(starts[3]), 32'h21);
        check_output("loop_replay2", 32'(starts[8]), 32'h84);
      end else begin
        check_output("loop_nstarts", 32'(starts.size()), 32'd9);
      end
      clear_mon();
      pulse_go();
      repeat (20) tick();
      check_output("loop_cleared", 32'(n_start_cycles), 32'd0);
    end

    apply_stimulus(3000);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
